intr_ctrl: RTL and testbench
============================

# intr_ctrl

Parametrised multi-channel interrupt controller, the successor to the CPU's single `interrupt` input. It edge-detects `NUM_CH` request lines, latches them as pending, applies a software mask and fixed priority, and presents one vectored request to the decode stage. The request uses a req/ack handshake and the controller tracks in-service channels until the RTI retires. It sits beside `decode_stage`: `intr_req` replaces the raw interrupt line, and `intr_vec` feeds the fetch path as the vector-table address.

## Interface
- `NUM_CH`, 4: number of interrupt channels (1..16).
- `DATA_W`, 8: address width of `intr_vec`.
- `VEC_BASE`, 1: memory address of the channel-0 vector-table entry.
- `ID_W`, $clog2(NUM_CH) (min 1): width of `intr_id`; derived, not overridden.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq`  in  NUM_CH  request lines, synchronous to `clk`; a rising edge requests service.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_wdata`  in  NUM_CH  new mask value; 1 = channel enabled.
- `intr_ack`  in  1  one-cycle pulse from decode: request accepted.
- `intr_ret`  in  1  one-cycle pulse: RTI retired.
- `intr_req`  out  1  interrupt request to the pipeline.
- `intr_id`  out  ID_W  channel being requested.
- `intr_vec`  out  DATA_W  VEC_BASE + intr_id, truncated to DATA_W bits.
- `pending`  out  NUM_CH  latched, not-yet-acknowledged requests.
- `in_service`  out  NUM_CH  acknowledged, not-yet-returned channels.
- `busy`  out  1  |in_service.

## Operation
- Edge detect: `irq_q` is `irq` delayed by one cycle. A channel edges when `irq & ~irq_q`.
- Pending: a set on an edge; cleared only when `intr_ack` is accepted for that channel.
  - If a clear and a new edge hit the same bit together, the set wins.
  - Masked channels still latch pending.
- Mask: written on `mask_we`. Resets to all ones.
- Candidate: the lowest-index bit of `pending & mask` that is eligible (see Configuration).
- FSM states:
  - IDLE: no request and nothing in service. Goes to REQ when a candidate exists.
  - REQ: `intr_req`=1 with `intr_id`/`intr_vec` locked. Goes to SERVICE on `intr_ack`.
  - SERVICE: at least one channel in service. Goes to REQ on an eligible candidate. Goes to IDLE when `intr_ret` empties `in_service` and no candidate exists.
- Handshake:
  - A request is never withdrawn or re-prioritised once raised. Masking the locked channel or a higher-priority arrival does not change `intr_id` before the ack.
  - On the ack edge, `pending[id]` clears, `in_service[id]` sets, and `intr_req` drops.
- Return: `intr_ret` clears the lowest-index set bit of `in_service`.
  - Ignored when `in_service` is 0.
  - `intr_ret` and `intr_ack` in the same cycle: the clear is applied first, then the set.
- `intr_ack` while `intr_req`=0 is ignored.

## Timing
- Reset: `intr_req`, `intr_id`, `intr_vec`, `pending`, `in_service` and `busy` are all 0. `irq_q` resets to 0, so a line held high through reset requests once after release. Mask resets to all ones.
- Latency: an edge sampled at rising edge k makes `pending` visible after k. `intr_req`/`intr_id`/`intr_vec` are registered and visible after k+1.
- `intr_req` is asserted no earlier than the cycle after a return or ack that made a candidate eligible.
- Back-to-back: with two pending channels, the second `intr_req` asserts one cycle after the first `intr_ret` (non-nesting).
- Reset asserted mid-operation clears all state immediately (asynchronous). No request survives reset.

## Configuration
- `INTC_NESTING_EN` defined:
  - A candidate is eligible while in SERVICE if its index is lower than every set `in_service` bit.
  - Preemption nests up to `NUM_CH` deep.
- `INTC_NESTING_EN` undefined:
  - Candidates are eligible only when `in_service` is 0.
  - At most one `in_service` bit is ever set.

## Test plan
- Reset defaults, NUM_CH=4: pulse `irq[2]`. Expect `pending`=4'b0100 after 1 cycle, then `intr_req`=1, `intr_id`=2 and `intr_vec`=8'h03 after 2 cycles. Ack: `in_service`=4'b0100, `intr_req`=0. Ret: `in_service`=0, `busy`=0.
- Edges on `irq[3]` and `irq[1]` in the same cycle: expect `intr_id`=1 first. After ack+ret, expect `intr_id`=3 next.
- Mask: set `mask_wdata`=4'b1110, then pulse `irq[0]`. Expect `pending[0]`=1 and `intr_req`=0. Write 4'b1111: expect `intr_req`=1, `intr_id`=0 one cycle later.
- Lock: while `intr_req`=1 for id 2, raise `irq[0]`. Expect `intr_id` to stay 2 until ack. With nesting enabled, id 0 is then requested during SERVICE. With it disabled, id 0 waits for `intr_ret`.
- Collision: on the ack cycle for id 1, a new edge arrives on `irq[1]`. Expect `pending[1]`=1 and `in_service[1]`=1 after the edge.
- Async reset: drop `reset` while in REQ, between clock edges. Expect `intr_req`=0 and `pending`=0 before the next clock edge. Spurious `intr_ret` at idle: no state change.

Source files
------------

// File: rtl/intr_ctrl.sv
// Multi-channel vectored interrupt controller: edge-detected, maskable, fixed-priority
// requests with a req/ack/ret handshake. Define INTC_NESTING_EN to allow nested preemption.
module intr_ctrl #(
    parameter  int NUM_CH   = 4,
    parameter  int DATA_W   = 8,
    parameter  int VEC_BASE = 1,
    localparam int ID_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] irq,
    input  logic              mask_we,
    input  logic [NUM_CH-1:0] mask_wdata,
    input  logic              intr_ack,
    input  logic              intr_ret,
    output logic              intr_req,
    output logic [ID_W-1:0]   intr_id,
    output logic [DATA_W-1:0] intr_vec,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] in_service,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [NUM_CH-1:0]   r_irqQ;
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   r_mask;
    logic [NUM_CH-1:0]   r_inService;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_vec;

    logic [NUM_CH-1:0]   w_edge;
    logic [NUM_CH-1:0]   w_cand;
    logic                w_candValid;
    logic [ID_W-1:0]     w_candIdx;
    logic [NUM_CH-1:0]   w_svcLowHot;
    logic [NUM_CH-1:0]   w_ackHot;
    logic                w_ackFire;
    logic                w_retFire;
    logic                w_eligible;
    logic                w_load;
    logic [NUM_CH-1:0]   w_pendingNext;
    logic [NUM_CH-1:0]   w_inServiceNext;
`ifdef INTC_NESTING_EN
    logic [ID_W-1:0]     w_svcLowIdx;
`endif

    assign w_edge    = irq & ~r_irqQ;
    assign w_cand    = r_pending & r_mask;
    assign w_ackFire = intr_ack && (r_state == REQ);
    assign w_retFire = intr_ret && (r_inService != '0);
    assign w_ackHot  = NUM_CH'(1) << r_id;

    // Lowest-index candidate and lowest-index in-service channel (the one RTI retires).
    always_comb begin
        w_candValid = 1'b0;
        w_candIdx   = '0;
        w_svcLowHot = '0;
`ifdef INTC_NESTING_EN
        w_svcLowIdx = '0;
`endif
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_candValid = 1'b1;
                w_candIdx   = ID_W'(i);
            end
            if (r_inService[i]) begin
                w_svcLowHot = NUM_CH'(1) << i;
`ifdef INTC_NESTING_EN
                w_svcLowIdx = ID_W'(i);
`endif
            end
        end
    end

`ifdef INTC_NESTING_EN
    assign w_eligible = w_candValid && ((r_inService == '0) || (w_candIdx < w_svcLowIdx));
`else
    assign w_eligible = w_candValid && (r_inService == '0);
`endif

    // Return clears before ack sets; a fresh edge beats the ack clear.
    assign w_inServiceNext = (r_inService & ~(w_retFire ? w_svcLowHot : '0))
                           | (w_ackFire ? w_ackHot : '0);
    assign w_pendingNext   = (r_pending & ~(w_ackFire ? w_ackHot : '0)) | w_edge;

    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_eligible) begin
                    w_stateNext = REQ;
                    w_load      = 1'b1;
                end
            end
            REQ: begin
                if (w_ackFire) begin
                    w_stateNext = SERVICE;
                end
            end
            SERVICE: begin
                if (w_eligible) begin
                    w_stateNext = REQ;
                    w_load      = 1'b1;
                end else if (w_inServiceNext == '0) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_irqQ      <= '0;
            r_pending   <= '0;
            r_mask      <= '1;
            r_inService <= '0;
            r_id        <= '0;
            r_vec       <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_irqQ      <= irq;
            r_pending   <= w_pendingNext;
            r_inService <= w_inServiceNext;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
            if (w_load) begin
                r_id  <= w_candIdx;
                r_vec <= DATA_W'(VEC_BASE) + DATA_W'(w_candIdx);
            end
        end
    end

    assign intr_req   = (r_state == REQ);
    assign intr_id    = r_id;
    assign intr_vec   = r_vec;
    assign pending    = r_pending;
    assign in_service = r_inService;
    assign busy       = |r_inService;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl (NUM_CH=4, DATA_W=8, VEC_BASE=1).
// Expected values are hand-computed; the nesting branch follows INTC_NESTING_EN.
module tb_intr_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       intr_ack;
    logic       intr_ret;
    logic       intr_req;
    logic [1:0] intr_id;
    logic [7:0] intr_vec;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic       busy;

    int totalChecks = 0;
    int badChecks   = 0;

    intr_ctrl #(.NUM_CH(4), .DATA_W(8), .VEC_BASE(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .intr_ack   (intr_ack),
        .intr_ret   (intr_ret),
        .intr_req   (intr_req),
        .intr_id    (intr_id),
        .intr_vec   (intr_vec),
        .pending    (pending),
        .in_service (in_service),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected)
        else begin
            badChecks++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic ackThenRet();
        intr_ack = 1'b1;
        applyStimulus(1);
        intr_ack = 1'b0;
        intr_ret = 1'b1;
        applyStimulus(1);
        intr_ret = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        irq        = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        intr_ack   = 1'b0;
        intr_ret   = 1'b0;
        #3;
        checkOutput("rst_req",  32'(intr_req),   32'h0);
        checkOutput("rst_id",   32'(intr_id),    32'h0);
        checkOutput("rst_vec",  32'(intr_vec),   32'h0);
        checkOutput("rst_pend", 32'(pending),    32'h0);
        checkOutput("rst_isvc", 32'(in_service), 32'h0);
        checkOutput("rst_busy", 32'(busy),       32'h0);
        #9 reset = 1'b1;
        applyStimulus(1);

        // Single request on channel 2
        irq = 4'b0100;
        applyStimulus(1);
        irq = 4'b0000;
        checkOutput("t1_pend", 32'(pending),  32'h4);
        checkOutput("t1_req0", 32'(intr_req), 32'h0);
        applyStimulus(1);
        checkOutput("t1_req", 32'(intr_req), 32'h1);
        checkOutput("t1_id",  32'(intr_id),  32'h2);
        checkOutput("t1_vec", 32'(intr_vec), 32'h03);
        intr_ack = 1'b1;
        applyStimulus(1);
        intr_ack = 1'b0;
        checkOutput("t1_isvc",    32'(in_service), 32'h4);
        checkOutput("t1_reqack",  32'(intr_req),   32'h0);
        checkOutput("t1_pendack", 32'(pending),    32'h0);
        checkOutput("t1_busy",    32'(busy),       32'h1);
        intr_ret = 1'b1;
        applyStimulus(1);
        intr_ret = 1'b0;
        checkOutput("t1_isvcret", 32'(in_service), 32'h0);
        checkOutput("t1_busyret", 32'(busy),       32'h0);
        applyStimulus(1);

        // Simultaneous edges on 3 and 1: priority then back-to-back
        irq = 4'b1010;
        applyStimulus(1);
        irq = 4'b0000;
        checkOutput("t2_pend", 32'(pending), 32'ha);
        applyStimulus(1);
        checkOutput("t2_req1", 32'(intr_req), 32'h1);
        checkOutput("t2_id1",  32'(intr_id),  32'h1);
        intr_ack = 1'b1;
        applyStimulus(1);
        intr_ack = 1'b0;
        checkOutput("t2_isvc", 32'(in_service), 32'h2);
        checkOutput("t2_pend2", 32'(pending),   32'h8);
        checkOutput("t2_busyreq", 32'(intr_req), 32'h0);
        intr_ret = 1'b1;
        applyStimulus(1);
        intr_ret = 1'b0;
        checkOutput("t2_isvcret", 32'(in_service), 32'h0);
        applyStimulus(1);
        checkOutput("t2_req3", 32'(intr_req), 32'h1);
        checkOutput("t2_id3",  32'(intr_id),  32'h3);
        checkOutput("t2_vec3", 32'(intr_vec), 32'h04);
        ackThenRet();
        applyStimulus(1);

        // Masked channel still latches pending but does not request
        mask_we    = 1'b1;
        mask_wdata = 4'b1110;
        applyStimulus(1);
        mask_we = 1'b0;
        irq     = 4'b0001;
        applyStimulus(1);
        irq = 4'b0000;
        checkOutput("t3_pend", 32'(pending), 32'h1);
        applyStimulus(1);
        checkOutput("t3_masked", 32'(intr_req), 32'h0);
        mask_we    = 1'b1;
        mask_wdata = 4'b1111;
        applyStimulus(1);
        mask_we = 1'b0;
        checkOutput("t3_notyet", 32'(intr_req), 32'h0);
        applyStimulus(1);
        checkOutput("t3_req", 32'(intr_req), 32'h1);
        checkOutput("t3_id",  32'(intr_id),  32'h0);
        ackThenRet();
        applyStimulus(1);

        // Locked request is not re-prioritised by a higher-priority arrival
        irq = 4'b0100;
        applyStimulus(1);
        irq = 4'b0000;
        applyStimulus(1);
        checkOutput("t4_id2", 32'(intr_id), 32'h2);
        irq = 4'b0001;
        applyStimulus(1);
        irq = 4'b0000;
        checkOutput("t4_lockid",  32'(intr_id),  32'h2);
        checkOutput("t4_lockreq", 32'(intr_req), 32'h1);
        checkOutput("t4_pend",    32'(pending),  32'h5);
        applyStimulus(1);
        checkOutput("t4_lockid2", 32'(intr_id), 32'h2);
        intr_ack = 1'b1;
        applyStimulus(1);
        intr_ack = 1'b0;
        checkOutput("t4_isvc",   32'(in_service), 32'h4);
        checkOutput("t4_reqack", 32'(intr_req),   32'h0);
        checkOutput("t4_pend0",  32'(pending),    32'h1);
        applyStimulus(1);
`ifdef INTC_NESTING_EN
        checkOutput("t4_nestreq", 32'(intr_req), 32'h1);
        checkOutput("t4_nestid",  32'(intr_id),  32'h0);
        intr_ack = 1'b1;
        applyStimulus(1);
        intr_ack = 1'b0;
        checkOutput("t4_nestisvc", 32'(in_service), 32'h5);
        intr_ret = 1'b1;
        applyStimulus(1);
        checkOutput("t4_ret0", 32'(in_service), 32'h4);
        applyStimulus(1);
        intr_ret = 1'b0;
        checkOutput("t4_ret2", 32'(in_service), 32'h0);
`else
        checkOutput("t4_wait", 32'(intr_req), 32'h0);
        intr_ret = 1'b1;
        applyStimulus(1);
        intr_ret = 1'b0;
        checkOutput("t4_isvcret", 32'(in_service), 32'h0);
        applyStimulus(1);
        checkOutput("t4_req0", 32'(intr_req), 32'h1);
        checkOutput("t4_id0",  32'(intr_id),  32'h0);
        ackThenRet();
`endif
        applyStimulus(1);

        // New edge on the same channel as the ack: set wins over clear
        irq = 4'b0010;
        applyStimulus(1);
        irq = 4'b0000;
        applyStimulus(1);
        checkOutput("t5_id1", 32'(intr_id), 32'h1);
        intr_ack = 1'b1;
        irq      = 4'b0010;
        applyStimulus(1);
        intr_ack = 1'b0;
        irq      = 4'b0000;
        checkOutput("t5_pend", 32'(pending),    32'h2);
        checkOutput("t5_isvc", 32'(in_service), 32'h2);
        intr_ret = 1'b1;
        applyStimulus(1);
        intr_ret = 1'b0;
        applyStimulus(1);
        checkOutput("t5_rereq", 32'(intr_req), 32'h1);
        checkOutput("t5_reid",  32'(intr_id),  32'h1);
        ackThenRet();
        applyStimulus(1);
        checkOutput("t5_clean", 32'(pending), 32'h0);

        // Asynchronous reset between clock edges while requesting
        irq = 4'b1000;
        applyStimulus(1);
        irq = 4'b0000;
        applyStimulus(1);
        checkOutput("t6_req", 32'(intr_req), 32'h1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t6_rstreq",  32'(intr_req), 32'h0);
        checkOutput("t6_rstpend", 32'(pending),  32'h0);
        checkOutput("t6_rstid",   32'(intr_id),  32'h0);
        #1 reset = 1'b1;
        applyStimulus(1);
        checkOutput("t6_nosurv", 32'(intr_req), 32'h0);
        intr_ret = 1'b1;
        applyStimulus(1);
        intr_ret = 1'b0;
        checkOutput("t6_spurisvc", 32'(in_service), 32'h0);
        checkOutput("t6_spurpend", 32'(pending),    32'h0);
        checkOutput("t6_spurbusy", 32'(busy),       32'h0);
        applyStimulus(1);
        checkOutput("t6_spurreq", 32'(intr_req), 32'h0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
